// File: rtl/mskaes_ctrl_pkg.sv
// Shared constants and state encoding for the masked AES-128 controllers.
package mskaes_ctrl_pkg;

  // Latency of the HPC masked S-box, same for state and key-schedule pipelines.
  localparam int unsigned SBOX_LAT_DEFAULT = 6;
  localparam int unsigned NROUNDS          = 10;
  // rcon after NROUNDS forward key-schedule steps: xtime^10(0x01).
  localparam logic [7:0]  RCON_END         = 8'h6c;

  typedef enum logic [2:0] {
    StIdle,
    StKeyPre,
    StArk0,
    StWaitR,
    StWaitLastR
  } ctrl_state_e;

endpackage

// File: rtl/mskaes_round_timer.sv
// Cycle-within-round and round counters shared by the AES controllers.
module mskaes_round_timer
  import mskaes_ctrl_pkg::*;
#(
  parameter int unsigned SboxLat = SBOX_LAT_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cnt_en_i,
  input  logic       cnt_clr_i,
  input  logic       rnd_inc_i,
  input  logic       rnd_clr_i,
  output logic       cnt_zero_o,
  output logic       last_cycle_o,
  output logic [3:0] round_o
);

  logic [3:0] cnt_fsm_q, cnt_fsm_d;
  logic [3:0] cnt_rounds_q, cnt_rounds_d;

  assign cnt_zero_o   = (cnt_fsm_q == 4'd0);
  assign last_cycle_o = (cnt_fsm_q == 4'(SboxLat));
  assign round_o      = cnt_rounds_q;

  // Next-state: the cycle counter wraps to zero on the last S-box cycle.
  always_comb begin
    cnt_fsm_d    = cnt_fsm_q;
    cnt_rounds_d = cnt_rounds_q;
    if (cnt_clr_i || (cnt_en_i && last_cycle_o)) begin
      cnt_fsm_d = 4'd0;
    end else if (cnt_en_i) begin
      cnt_fsm_d = cnt_fsm_q + 4'd1;
    end
    if (rnd_clr_i) begin
      cnt_rounds_d = 4'd0;
    end else if (rnd_inc_i) begin
      cnt_rounds_d = cnt_rounds_q + 4'd1;
    end
  end

  // Counter registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_fsm_q    <= 4'd0;
      cnt_rounds_q <= 4'd0;
    end else begin
      cnt_fsm_q    <= cnt_fsm_d;
      cnt_rounds_q <= cnt_rounds_d;
    end
  end

endmodule

// File: rtl/mskaes_128bits_inv_fsm.sv
// Control FSM for the masked AES-128 decryption datapath: forward key
// pre-expansion to round key 10 (optional), initial AddRoundKey, 9 inverse
// rounds and a final round without InvMixColumns.
module mskaes_128bits_inv_fsm
  import mskaes_ctrl_pkg::*;
#(
  parameter int unsigned SBOX_LAT = SBOX_LAT_DEFAULT
) (
  input  logic clk,
  input  logic nrst,
  input  logic valid_in,
  input  logic key_is_last,
  output logic ready,
  output logic plain_valid,
  output logic feed_in,
  output logic state_reg_enable,
  output logic state_mux_ark0,
  output logic state_mux_lastR,
  output logic key_reg_enable,
  output logic SB_valid_in,
  output logic KS_in_valid,
  output logic KS_dir,
  output logic KS_rcon_update,
  output logic KS_rcon_rst,
  output logic KS_rcon_set_end
);

  ctrl_state_e state_q, state_d;
  logic        plain_valid_q, plain_valid_d;

  logic       cnt_en, cnt_clr, rnd_inc, rnd_clr;
  logic       cnt_zero, last_cycle;
  logic [3:0] round;

  mskaes_round_timer #(
    .SboxLat (SBOX_LAT)
  ) u_timer (
    .clk          (clk),
    .nrst         (nrst),
    .cnt_en_i     (cnt_en),
    .cnt_clr_i    (cnt_clr),
    .rnd_inc_i    (rnd_inc),
    .rnd_clr_i    (rnd_clr),
    .cnt_zero_o   (cnt_zero),
    .last_cycle_o (last_cycle),
    .round_o      (round)
  );

  assign plain_valid = plain_valid_q;

  // Next-state and strobe decode.
  always_comb begin
    state_d          = state_q;
    ready            = 1'b0;
    feed_in          = 1'b0;
    state_reg_enable = 1'b0;
    state_mux_ark0   = 1'b0;
    state_mux_lastR  = 1'b0;
    key_reg_enable   = 1'b0;
    SB_valid_in      = 1'b0;
    KS_in_valid      = 1'b0;
    KS_dir           = 1'b0;
    KS_rcon_update   = 1'b0;
    KS_rcon_rst      = 1'b0;
    KS_rcon_set_end  = 1'b0;
    cnt_en           = 1'b0;
    cnt_clr          = 1'b0;
    rnd_inc          = 1'b0;
    rnd_clr          = 1'b0;
    plain_valid_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready            = 1'b1;
        // Registers track the inputs while idle so the accept cycle loads them.
        feed_in          = 1'b1;
        state_reg_enable = 1'b1;
        key_reg_enable   = 1'b1;
        if (valid_in) begin
          cnt_clr = 1'b1;
          rnd_clr = 1'b1;
          if (key_is_last) begin
            KS_rcon_set_end = 1'b1;
            state_d         = StArk0;
          end else begin
            KS_rcon_rst = 1'b1;
            state_d     = StKeyPre;
          end
        end
      end

      StKeyPre: begin
        cnt_en      = 1'b1;
        KS_in_valid = cnt_zero;
        if (last_cycle) begin
          key_reg_enable = 1'b1;
          KS_rcon_update = 1'b1;
          if (round == 4'(NROUNDS - 1)) begin
            rnd_clr = 1'b1;
            state_d = StArk0;
          end else begin
            rnd_inc = 1'b1;
          end
        end
      end

      StArk0: begin
        state_reg_enable = 1'b1;
        state_mux_ark0   = 1'b1;
        state_d          = StWaitR;
      end

      StWaitR, StWaitLastR: begin
        KS_dir = 1'b1;
        cnt_en = 1'b1;
        if (cnt_zero) begin
          KS_in_valid = 1'b1;
          SB_valid_in = 1'b1;
        end
        if (last_cycle) begin
          state_reg_enable = 1'b1;
          key_reg_enable   = 1'b1;
          KS_rcon_update   = 1'b1;
          if (state_q == StWaitLastR) begin
            state_mux_lastR = 1'b1;
            rnd_clr         = 1'b1;
            plain_valid_d   = 1'b1;
            state_d         = StIdle;
          end else begin
            rnd_inc = 1'b1;
            if (round == 4'(NROUNDS - 2)) begin
              state_d = StWaitLastR;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register and registered plaintext strobe.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= StIdle;
      plain_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      plain_valid_q <= plain_valid_d;
    end
  end

endmodule

// File: tb/tb_mskaes_128bits_inv_fsm.sv
// Bench for the AES decryption controller: strobe tables per cycle plus an
// unmasked AES datapath model steered only by the controller's strobes.
module tb_mskaes_128bits_inv_fsm;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic valid_in = 1'b0;
  logic key_is_last = 1'b0;
  logic ready, plain_valid, feed_in, state_reg_enable, state_mux_ark0, state_mux_lastR;
  logic key_reg_enable, SB_valid_in, KS_in_valid, KS_dir, KS_rcon_update;
  logic KS_rcon_rst, KS_rcon_set_end;

  always #5 clk = ~clk;

  mskaes_128bits_inv_fsm #(
    .SBOX_LAT (6)
  ) dut (
    .clk              (clk),
    .nrst             (nrst),
    .valid_in         (valid_in),
    .key_is_last      (key_is_last),
    .ready            (ready),
    .plain_valid      (plain_valid),
    .feed_in          (feed_in),
    .state_reg_enable (state_reg_enable),
    .state_mux_ark0   (state_mux_ark0),
    .state_mux_lastR  (state_mux_lastR),
    .key_reg_enable   (key_reg_enable),
    .SB_valid_in      (SB_valid_in),
    .KS_in_valid      (KS_in_valid),
    .KS_dir           (KS_dir),
    .KS_rcon_update   (KS_rcon_update),
    .KS_rcon_rst      (KS_rcon_rst),
    .KS_rcon_set_end  (KS_rcon_set_end)
  );

  localparam logic [12:0] O_READY = 13'h1000, O_PV   = 13'h0800, O_FEED = 13'h0400;
  localparam logic [12:0] O_SRE   = 13'h0200, O_ARK0 = 13'h0100, O_LAST = 13'h0080;
  localparam logic [12:0] O_KRE   = 13'h0040, O_SBV  = 13'h0020, O_KSV  = 13'h0010;
  localparam logic [12:0] O_DIR   = 13'h0008, O_UPD  = 13'h0004, O_RST  = 13'h0002;
  localparam logic [12:0] O_SETE  = 13'h0001;
  localparam logic [12:0] HOLD    = O_READY | O_FEED | O_SRE | O_KRE;
  localparam logic [12:0] RND_END = O_DIR | O_SRE | O_KRE | O_UPD;
  localparam logic [12:0] RND_GO  = O_DIR | O_KSV | O_SBV;

  localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic [12:0] outs;
  assign outs = {ready, plain_valid, feed_in, state_reg_enable, state_mux_ark0,
                 state_mux_lastR, key_reg_enable, SB_valid_in, KS_in_valid, KS_dir,
                 KS_rcon_update, KS_rcon_rst, KS_rcon_set_end};

  int n_pass = 0;
  int n_total = 0;
  logic [12:0] olog [320];

  typedef struct {
    bit          kil;
    int          cyc;
    logic [12:0] exp;
  } vec_t;
  vec_t tab [19];

  // ---------------- AES reference functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xt(input logic [7:0] a);
    logic [7:0] t;
    t = a[0] ? (a ^ 8'h1b) : a;
    return {a[0], t[7:1]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b, o;
    logic [7:0] c = 8'h63;
    b = ginv(x);
    for (int i = 0; i < 8; i++)
      o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return o;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    logic [7:0] o;
    logic [7:0] d = 8'h05;
    for (int i = 0; i < 8; i++)
      o[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ d[i];
    return ginv(o);
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] ks_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ subrot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] ks_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ subrot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [7:0] b0, b1, b2, b3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = s[127 - 8 * i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        t[rr + 4 * c] = isbox(a[rr + 4 * ((c - rr + 4) % 4)]) ^ k[127 - 8 * (rr + 4 * c) -: 8];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        b0 = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
        b1 = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
        b2 = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
        b3 = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
        t[4*c] = b0; t[4*c+1] = b1; t[4*c+2] = b2; t[4*c+3] = b3;
      end
    end
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = t[i];
    return r;
  endfunction

  // ---------------- datapath model driven by the strobes ----------------
  logic [127:0] key_in = KEY0;
  logic [127:0] m_key = '0;
  logic [127:0] m_state = '0;
  logic [7:0]   m_rcon = 8'h00;

  always @(posedge clk) begin : model
    logic [127:0] nk;
    nk = m_key;
    if ((key_reg_enable || state_reg_enable) && !feed_in && !state_mux_ark0)
      nk = KS_dir ? ks_inv(m_key, inv_xt(m_rcon)) : ks_fwd(m_key, m_rcon);
    if (key_reg_enable) m_key <= feed_in ? key_in : nk;
    if (state_reg_enable) begin
      if (feed_in)             m_state <= CT;
      else if (state_mux_ark0) m_state <= m_state ^ m_key;
      else                     m_state <= inv_round(m_state, nk, state_mux_lastR);
    end
    if (KS_rcon_rst)          m_rcon <= 8'h01;
    else if (KS_rcon_set_end) m_rcon <= 8'h6c;
    else if (KS_rcon_update)  m_rcon <= KS_dir ? inv_xt(m_rcon) : xt(m_rcon);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic start(input bit kil);
    @(negedge clk);
    valid_in = 1'b1;
    key_is_last = kil;
    #1 olog[0] = outs;
  endtask

  task automatic follow(input bit hold, input int limit, output int pv_cyc);
    pv_cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      valid_in = hold;
      #1 olog[c] = outs;
      if (plain_valid) begin
        pv_cyc = c;
        break;
      end
    end
  endtask

  task automatic check_run(input bit kil, input int pv, input int exp_ksf);
    int ksf = 0, ksv = 0, sbv = 0, ark = 0, pvs = 0;
    for (int i = 0; i < 19; i++)
      if (tab[i].kil == kil && tab[i].cyc <= pv && pv > 0)
        check($sformatf("run%0d_cyc%0d", kil, tab[i].cyc), 128'(olog[tab[i].cyc]),
              128'(tab[i].exp));
    for (int c = 0; c <= pv && pv > 0; c++) begin
      if ((olog[c] & O_KSV) != 0 && (olog[c] & O_DIR) == 0) ksf++;
      if ((olog[c] & O_KSV) != 0) ksv++;
      if ((olog[c] & O_SBV) != 0) sbv++;
      if ((olog[c] & O_ARK0) != 0) ark++;
      if ((olog[c] & O_PV) != 0) pvs++;
    end
    check($sformatf("run%0d_ks_fwd_count", kil), 128'(ksf), 128'(exp_ksf));
    check($sformatf("run%0d_ks_total", kil), 128'(ksv), 128'(exp_ksf + 10));
    check($sformatf("run%0d_sb_count", kil), 128'(sbv), 128'd10);
    check($sformatf("run%0d_ark0_count", kil), 128'(ark), 128'd1);
    check($sformatf("run%0d_pv_count", kil), 128'(pvs), 128'd1);
    check($sformatf("run%0d_plaintext", kil), m_state, PT);
    check($sformatf("run%0d_rcon_end", kil), 128'(m_rcon), 128'h01);
    check($sformatf("run%0d_key_end", kil), m_key, KEY0);
  endtask

  initial begin
    int pv, pv2, npv;
    tab = '{
      '{0, 0, HOLD | O_RST}, '{0, 1, O_KSV}, '{0, 2, 13'h0},
      '{0, 7, O_KRE | O_UPD}, '{0, 8, O_KSV}, '{0, 70, O_KRE | O_UPD},
      '{0, 71, O_SRE | O_ARK0}, '{0, 72, RND_GO}, '{0, 73, O_DIR},
      '{0, 78, RND_END}, '{0, 134, RND_END}, '{0, 135, RND_GO},
      '{0, 141, RND_END | O_LAST}, '{0, 142, HOLD | O_PV},
      '{1, 0, HOLD | O_SETE}, '{1, 1, O_SRE | O_ARK0}, '{1, 2, RND_GO},
      '{1, 71, RND_END | O_LAST}, '{1, 72, HOLD | O_PV}
    };

    // Reset with valid_in low, then idle holder for 10 cycles.
    repeat (2) @(negedge clk);
    #1 check("reset_during", 128'(outs), 128'(HOLD));
    @(negedge clk);
    nrst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1 check($sformatf("reset_idle%0d", c), 128'(outs), 128'(HOLD));
      @(negedge clk);
    end

    // Full run with key pre-expansion.
    key_in = KEY0;
    start(1'b0);
    follow(1'b0, 300, pv);
    check("run0_latency", 128'(pv), 128'd142);
    check_run(1'b0, pv, 10);

    // Key supplied as round key 10.
    key_in = KEY10;
    start(1'b1);
    follow(1'b0, 300, pv);
    check("run1_latency", 128'(pv), 128'd72);
    check_run(1'b1, pv, 0);
    key_is_last = 1'b0;
    key_in = KEY0;

    // valid_in held high: back-to-back runs, mid-run valid ignored.
    start(1'b0);
    follow(1'b1, 300, pv);
    check("b2b_first_latency", 128'(pv), 128'd142);
    check("b2b_first_pt", m_state, PT);
    check("b2b_accept_in_pv", 128'(olog[pv]), 128'(HOLD | O_PV | O_RST));
    follow(1'b1, 300, pv2);
    check("b2b_second_latency", 128'(pv2), 128'd142);
    check("b2b_second_pt", m_state, PT);

    // Third run was accepted in that pv cycle; reset it at cycle 100.
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    #1 check("midrun_reset_idle", 128'(outs), 128'(HOLD));
    npv = 0;
    for (int c = 0; c < 160; c++) begin
      @(negedge clk);
      #1 if (plain_valid) npv++;
    end
    check("midrun_reset_no_pv", 128'(npv), 128'd0);
    start(1'b0);
    follow(1'b0, 300, pv);
    check("after_reset_latency", 128'(pv), 128'd142);
    check("after_reset_pt", m_state, PT);
    valid_in = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
